// File: rtl/piso_sched.sv
// Round-robin scheduler for a shared parallel-in/serial-out shift register.
// Grants one requester, drives the register load port, then times WIDTH shift cycles plus GAP idle cycles.
module piso_sched #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             piso_mode,
  output logic [WIDTH-1:0] piso_in,
  output logic             frame_valid,
  output logic             frame_last,
  output logic             grant_id,
  output logic             busy
);

  localparam int MAXC = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHIFT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_INIT   = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             gid_q, gid_d;
  logic             ptr_q, ptr_d;
  logic             win_s;

  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             piso_mode_q, piso_mode_d;
  logic [WIDTH-1:0] piso_in_q, piso_in_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_last_q, frame_last_d;
  logic             grant_id_q, grant_id_d;
  logic             busy_q, busy_d;

  // State, sequencing and output registers; reset forces every output low at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      word_q        <= '0;
      gid_q         <= 1'b0;
      ptr_q         <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      piso_mode_q   <= 1'b0;
      piso_in_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_last_q  <= 1'b0;
      grant_id_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      gid_q         <= gid_d;
      ptr_q         <= ptr_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      piso_mode_q   <= piso_mode_d;
      piso_in_q     <= piso_in_d;
      frame_valid_q <= frame_valid_d;
      frame_last_q  <= frame_last_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
    end
  end

  // Next state: arbitration in IDLE, then fixed-length LOAD/SHIFT/GAP sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    win_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Pointer names the requester that wins a tie; it always points away from the last winner
          if (req0 && req1) begin
            win_s = ptr_q;
          end else begin
            win_s = req1;
          end
          word_d  = win_s ? data1 : data0;
          gid_d   = win_s;
          ptr_d   = ~win_s;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        cnt_d   = SHIFT_INIT;
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          if (GAP == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
          cnt_d = GAP_INIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the current state; registered on the next edge
  always_comb begin
    piso_mode_d   = (state_q == S_LOAD);
    piso_in_d     = (state_q == S_LOAD) ? word_q : piso_in_q;
    ack0_d        = (state_q == S_LOAD) && !gid_q;
    ack1_d        = (state_q == S_LOAD) && gid_q;
    frame_valid_d = (state_q == S_SHIFT);
    frame_last_d  = (state_q == S_SHIFT) && (cnt_q == '0);
    grant_id_d    = gid_q;
    busy_d        = (state_q != S_IDLE);
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign piso_mode   = piso_mode_q;
  assign piso_in     = piso_in_q;
  assign frame_valid = frame_valid_q;
  assign frame_last  = frame_last_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_piso_sched.sv
// Scoreboard bench for piso_sched: stimulus pushes expected grants, a monitor checks each frame
// through a behavioural MSB-first piso; a second GAP=0 instance checks back-to-back framing.
module tb_piso_sched;

  logic       clk;
  logic       reset;
  logic       req0, req1;
  logic [3:0] data0, data1;
  logic       ack0, ack1, piso_mode, frame_valid, frame_last, grant_id, busy;
  logic [3:0] piso_in;

  logic       req0g;
  logic [3:0] data0g;
  logic       ack0g, ack1g, mode_g, fv_g, fl_g, gid_g, busy_g;
  logic [3:0] in_g;

  logic [3:0] sr;
  logic       piso_out;

  typedef struct packed {
    logic       id;
    logic [3:0] word;
  } exp_t;

  exp_t expq[$];
  exp_t e;

  int total = 0;
  int pass  = 0;
  int cyc   = 0;
  int phase = 0;
  bit per_en = 1'b0;
  int prev_ack = 0;
  int prev_phase = -1;
  int bit_idx = 0;
  bit in_frame = 1'b0;
  logic [3:0] cur_word = 4'b0000;
  bit g_en = 1'b0;
  bit g_started = 1'b0;
  int g_first = 0;

  piso_sched #(.WIDTH(4), .GAP(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .piso_mode(piso_mode), .piso_in(piso_in),
    .frame_valid(frame_valid), .frame_last(frame_last),
    .grant_id(grant_id), .busy(busy)
  );

  piso_sched #(.WIDTH(4), .GAP(0)) dut0 (
    .clk(clk), .reset(reset),
    .req0(req0g), .data0(data0g), .req1(1'b0), .data1(4'b0000),
    .ack0(ack0g), .ack1(ack1g), .piso_mode(mode_g), .piso_in(in_g),
    .frame_valid(fv_g), .frame_last(fl_g),
    .grant_id(gid_g), .busy(busy_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the shared shift register, shifting MSB first
  always @(posedge clk or negedge reset) begin
    if (!reset) sr <= 4'b0000;
    else if (piso_mode) sr <= piso_in;
    else sr <= {sr[2:0], 1'b0};
  end
  assign piso_out = sr[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor for the GAP=1 instance
  always @(negedge clk) begin
    if (!reset) begin
      bit_idx  = 0;
      in_frame = 1'b0;
    end else begin
      chk("mode_eq_ack", piso_mode, ack0 | ack1);
      if (ack0 || ack1) begin
        chk("ack_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("ack_id", {ack1, ack0}, e.id ? 2'b10 : 2'b01);
          chk("grant_id", grant_id, e.id);
          chk("piso_in", piso_in, e.word);
          chk("busy_in_load", busy, 1);
          cur_word = e.word;
          bit_idx  = 0;
          in_frame = 1'b1;
          if (per_en && prev_phase == phase) chk("period", cyc - prev_ack, 7);
          prev_ack   = cyc;
          prev_phase = phase;
        end
      end
      if (frame_valid) begin
        chk("fv_in_frame", in_frame, 1);
        if (in_frame) begin
          chk("serial_bit", piso_out, cur_word[3 - bit_idx]);
          chk("frame_last", frame_last, bit_idx == 3);
          if (bit_idx == 3) in_frame = 1'b0;
          bit_idx++;
        end
      end else begin
        chk("last_needs_valid", frame_last, 0);
      end
    end
  end

  // Monitor for the GAP=0 instance: 6-cycle period, LOAD at offset 0, bits at offsets 1..4
  always @(negedge clk) begin
    if (g_en && reset) begin
      if (!g_started) begin
        if (ack0g) begin
          g_started = 1'b1;
          g_first   = cyc;
          chk("g0_in", in_g, 4'b1001);
        end
      end else begin
        int o;
        o = (cyc - g_first) % 6;
        chk("g0_ack", ack0g, o == 0);
        chk("g0_mode", mode_g, o == 0);
        chk("g0_fv", fv_g, (o >= 1) && (o <= 4));
        chk("g0_last", fl_g, o == 4);
        chk("g0_busy", busy_g, o != 5);
        if (o == 0) chk("g0_in", in_g, 4'b1001);
      end
    end
  end

  task automatic wait_acks(input int n);
    int seen;
    int t;
    seen = 0;
    t = 0;
    while (seen < n && t < 60) begin
      @(negedge clk);
      t++;
      if (ack0 || ack1) seen++;
    end
    if (seen < n) chk("ack_timeout", seen, n);
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; data0 = 4'b0000; data1 = 4'b0000;
    req0g = 1'b0; data0g = 4'b0000;

    // Reset held with req0 high: everything stays low
    phase = 1;
    req0 = 1'b1; data0 = 4'b0110;
    repeat (2) begin
      @(negedge clk);
      chk("rst_outs", {ack0, ack1, piso_mode, piso_in, frame_valid, frame_last, grant_id, busy}, 11'd0);
      chk("rst_outs_g0", {ack0g, ack1g, mode_g, in_g, fv_g, fl_g, gid_g, busy_g}, 11'd0);
    end
    expq.push_back('{id: 1'b0, word: 4'b0110});
    reset = 1'b1;
    @(posedge clk); #1;
    chk("no_ack_1st_edge", ack0, 0);
    @(posedge clk); #1;
    chk("ack0_2nd_edge", ack0, 1);
    chk("piso_in_2nd_edge", piso_in, 4'b0110);
    @(negedge clk);
    req0 = 1'b0;
    settle();

    // Single word, then busy drops right after the GAP cycle
    phase = 2;
    data0 = 4'b1011;
    expq.push_back('{id: 1'b0, word: 4'b1011});
    req0 = 1'b1;
    wait_acks(1);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_in_gap", busy, 1);
    chk("fv_in_gap", frame_valid, 0);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    settle();

    // Contention after reset: 0,1,0,1 with 7-cycle spacing
    apply_reset();
    phase = 3;
    per_en = 1'b1;
    data0 = 4'b1011; data1 = 4'b1100;
    expq.push_back('{id: 1'b0, word: 4'b1011});
    expq.push_back('{id: 1'b1, word: 4'b1100});
    expq.push_back('{id: 1'b0, word: 4'b1011});
    expq.push_back('{id: 1'b1, word: 4'b1100});
    req0 = 1'b1; req1 = 1'b1;
    wait_acks(4);
    req0 = 1'b0; req1 = 1'b0;
    per_en = 1'b0;
    settle();

    // Late request: req1 raised mid-SHIFT waits a full frame period
    phase = 4;
    per_en = 1'b1;
    data0 = 4'b0101;
    expq.push_back('{id: 1'b0, word: 4'b0101});
    req0 = 1'b1;
    wait_acks(1);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    data1 = 4'b0011;
    expq.push_back('{id: 1'b1, word: 4'b0011});
    req1 = 1'b1;
    wait_acks(1);
    req1 = 1'b0;
    per_en = 1'b0;
    settle();

    // Reset on the 2nd SHIFT cycle, then both request: req0 wins first
    phase = 5;
    data0 = 4'b1110;
    expq.push_back('{id: 1'b0, word: 4'b1110});
    req0 = 1'b1;
    wait_acks(1);
    req0 = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_outs", {ack0, ack1, piso_mode, piso_in, frame_valid, frame_last, grant_id, busy}, 11'd0);
    data0 = 4'b0001; data1 = 4'b1000;
    req0 = 1'b1; req1 = 1'b1;
    expq.push_back('{id: 1'b0, word: 4'b0001});
    expq.push_back('{id: 1'b1, word: 4'b1000});
    @(negedge clk);
    reset = 1'b1;
    wait_acks(1);
    req0 = 1'b0;
    wait_acks(1);
    req1 = 1'b0;
    settle();

    // GAP=0 instance with req0 held high
    phase = 6;
    data0g = 4'b1001;
    req0g = 1'b1;
    g_en = 1'b1;
    repeat (30) @(negedge clk);
    g_en = 1'b0;
    req0g = 1'b0;
    chk("g0_started", g_started, 1);
    settle();

    chk("queue_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
